// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants: reset PC, NOP encoding, PC step, queue entry.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // One fetch-queue entry: the fetched word together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer holding {pc, instr} entries between fetch and decode.
// QUEUE_DEPTH is expected to be 2 or 4; pointers wrap explicitly at QUEUE_DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH),
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    fetch_entry_t     mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy update; flush empties the buffer outright
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset discards contents by clearing occupancy immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; data needs no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(QUEUE_DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, push/pop/redirect arbitration and fetch queue.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky
// Misalign_o and halt fetching until reset; otherwise target bits [1:0] are cleared.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned           QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] Fetch_address_o,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_target_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [DATA_WIDTH-1:0] Inst_pc_o,
    output logic                  Misalign_o
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [DATA_WIDTH-1:0] target_c;
    logic [CNT_W-1:0]      count_c;
    logic                  full_c, valid_c, push_c, pop_c, halt_c;
    fetch_entry_t          head_c, entry_c;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // A redirect to a non-word address latches the sticky flag, which also halts fetch
    always_comb begin
        misalign_d = misalign_q;
        if (Redirect_i && (Redirect_target_i[1:0] != 2'b00)) misalign_d = 1'b1;
    end

    // Sticky misalign/halt flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    assign target_c   = Redirect_target_i;
    assign halt_c     = misalign_q;
    assign Misalign_o = misalign_q;
`else
    assign target_c   = Redirect_target_i & ~DATA_WIDTH'(3);
    assign halt_c     = 1'b0;
    assign Misalign_o = 1'b0;
`endif

    // Redirect beats everything; pop needs a valid head, push needs room or a same-cycle pop
    assign valid_c = (count_c != '0);
    assign pop_c   = valid_c && Ready_i && !Redirect_i;
    assign push_c  = !Redirect_i && !halt_c && (!full_c || pop_c);
    assign entry_c = '{pc: XLEN'(pc_q), instr: XLEN'(Instruction_i)};

    // Next PC and the remembered head PC shown while the queue is empty
    always_comb begin
        pc_d      = pc_q;
        last_pc_d = last_pc_q;
        if (Redirect_i)  pc_d = target_c;
        else if (push_c) pc_d = pc_q + DATA_WIDTH'(PC_STEP);
        if (valid_c) last_pc_d = DATA_WIDTH'(head_c.pc);
    end

    // PC and last-head-PC registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            last_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (push_c),
        .pop_i  (pop_c),
        .flush_i(Redirect_i),
        .entry_i(entry_c),
        .head_o (head_c),
        .count_o(count_c),
        .full_o (full_c)
    );

    assign Fetch_address_o = pc_q;
    assign Valid_o         = valid_c;
    assign Instruction_o   = valid_c ? DATA_WIDTH'(head_c.instr) : DATA_WIDTH'(NOP_INSTR);
    assign Inst_pc_o       = valid_c ? DATA_WIDTH'(head_c.pc) : last_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] fetch_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] target;
    logic        valid;
    logic        ready;
    logic [31:0] instr_o;
    logic [31:0] inst_pc;
    logic        misalign;

    // Reference model state (post-edge) and the snapshot the monitor compares against
    ent_t        mq[$];
    ent_t        exp_q[$];
    logic [31:0] m_pc, m_last;
    bit          m_mis;
    logic [31:0] cur_pc, cur_last;
    bit          cur_valid, cur_mis;
    ent_t        cur_head;
    int          checks = 0;
    int          errors = 0;
    int          deliveries = 0;

    always #5 clk = ~clk;

    // Program memory: word k above RESET_PC holds 0x1000_0000 + k
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + ((a - RPC) >> 2);
    endfunction

    assign rom_data = rom(fetch_addr);

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset_n),
        .Fetch_address_o  (fetch_addr),
        .Instruction_i    (rom_data),
        .Redirect_i       (redirect),
        .Redirect_target_i(target),
        .Valid_o          (valid),
        .Ready_i          (ready),
        .Instruction_o    (instr_o),
        .Inst_pc_o        (inst_pc),
        .Misalign_o       (misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs for the coming edge and advance the model by the spec rules
    task automatic step(input bit r, input bit d, input logic [31:0] t);
        ent_t e;
        @(negedge clk);
        reset_n  = 1'b1;
        ready    = r;
        redirect = d;
        target   = t;
        cur_pc    = m_pc;
        cur_valid = (mq.size() != 0);
        cur_last  = m_last;
        cur_mis   = m_mis;
        cur_head  = '{pc: 32'd0, instr: 32'd0};
        if (cur_valid) cur_head = mq[0];
        if (d) begin
            mq.delete();
            if (MIS_EN) begin
                m_pc = t;
                if (t[1:0] != 2'b00) m_mis = 1'b1;
            end else begin
                m_pc = {t[31:2], 2'b00};
            end
        end else begin
            if (cur_valid && r) exp_q.push_back(mq.pop_front());
            if (!m_mis && mq.size() < int'(DEPTH)) begin
                e.pc    = m_pc;
                e.instr = rom(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (mq.size() != 0) m_last = mq[0].pc;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        mq.delete();
        m_pc = RPC; m_last = 32'd0; m_mis = 1'b0;
        cur_pc = RPC; cur_valid = 1'b0; cur_last = 32'd0; cur_mis = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_addr", fetch_addr, RPC);
        check("rst_instr", instr_o, NOP);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        repeat (cycles) @(negedge clk);
    endtask

    // Monitor: compare visible state just before each edge and retire delivered entries
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #4;
            check("fetch_addr", fetch_addr, cur_pc);
            check("valid", 32'(valid), 32'(cur_valid));
            check("misalign", 32'(misalign), 32'(cur_mis));
            if (cur_valid) begin
                check("head_pc", inst_pc, cur_head.pc);
                check("head_instr", instr_o, cur_head.instr);
            end else begin
                check("idle_instr", instr_o, NOP);
                check("idle_pc", inst_pc, cur_last);
            end
            if (valid && ready && !redirect && reset_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL delivery: got pc %h expected no delivery", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    deliveries++;
                    check("deliver_pc", inst_pc, e.pc);
                    check("deliver_instr", instr_o, e.instr);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic, reset and misalign cases
    initial begin
        logic [31:0] t;
        reset_n  = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        target   = 32'd0;
        m_pc = RPC; m_last = 32'd0; m_mis = 1'b0;
        cur_pc = RPC; cur_valid = 1'b0; cur_last = 32'd0; cur_mis = 1'b0;
        cur_head = '{pc: 32'd0, instr: 32'd0};
        do_reset(2);

        repeat (8) step(1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 32'd0);
        repeat (6) step(1'b1, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0040_0100);
        repeat (6) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_1000);
        step(1'b1, 1'b1, 32'h0000_2000);
        repeat (4) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
            if (MIS_EN) t[1:0] = 2'b00;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t);
        end

        do_reset(2);
        repeat (6) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0040_0102);
        for (int i = 0; i < 8; i++) step($urandom_range(0, 1) != 0, 1'b0, 32'd0);
        do_reset(2);
        repeat (5) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #5;

        check("pending_deliveries", 32'(exp_q.size()), 32'd0);
        check("delivered_any", 32'(deliveries > 100), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
